// File: rtl/dift_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dift_trap_ctrl
// Purpose  : Sequences DIFT tag-check trap pulses into a held exception
//            request with ack/flush handshake. Captures first-violation
//            status, blanks wrong-path checks for one cycle after a taken
//            trap, and optionally keeps saturating per-class counters.
// Options  : DIFT_TRAP_COUNTERS_EN builds the five violation counters;
//            without it cnt_data_o reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module dift_trap_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_i,
  input  logic [2:0]      trap_type_i,
  input  logic [PC_W-1:0] trap_pc_i,
  input  logic [4:0]      trap_mask_i,
  input  logic            exc_ack_i,
  input  logic            flush_i,
  input  logic            clear_i,
  output logic            exc_req_o,
  output logic [2:0]      exc_type_o,
  output logic [PC_W-1:0] exc_pc_o,
  output logic            busy_o,
  output logic            status_valid_o,
  output logic [2:0]      status_type_o,
  output logic [PC_W-1:0] status_pc_o,
  output logic            overflow_o,
  input  logic [2:0]      cnt_sel_i,
  output logic [CNT_W-1:0] cnt_data_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic [2:0]      exc_type_q;
  logic [PC_W-1:0] exc_pc_q;
  logic            status_valid_q;
  logic [2:0]      status_type_q;
  logic [PC_W-1:0] status_pc_q;
  logic            overflow_q;

  // Classes 5..7 are not real trap classes and never reach the mask lookup.
  logic trap_valid;
  logic trap_raise;
  assign trap_valid = trap_i && (trap_type_i <= 3'd4);
  assign trap_raise = trap_valid && trap_mask_i[trap_type_i];

  // State register; async reset drops any pending request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; ack takes precedence over flush while requesting.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trap_raise) begin
          state_d = S_REQ;
          accept  = 1'b1;
        end
      end
      S_REQ: begin
        if (exc_ack_i)    state_d = S_BLANK;
        else if (flush_i) state_d = S_IDLE;
      end
      S_BLANK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Exception fields latch only on acceptance so they stay stable in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_type_q <= 3'd0;
      exc_pc_q   <= '0;
    end else if (accept) begin
      exc_type_q <= trap_type_i;
      exc_pc_q   <= trap_pc_i;
    end
  end

  // First-violation status and drop flag; a software clear beats any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_valid_q <= 1'b0;
      status_type_q  <= 3'd0;
      status_pc_q    <= '0;
      overflow_q     <= 1'b0;
    end else if (clear_i) begin
      status_valid_q <= 1'b0;
      status_type_q  <= 3'd0;
      status_pc_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      if (accept && !status_valid_q) begin
        status_valid_q <= 1'b1;
        status_type_q  <= trap_type_i;
        status_pc_q    <= trap_pc_i;
      end
      if ((state_q == S_REQ) && trap_raise) overflow_q <= 1'b1;
    end
  end

  assign exc_req_o      = (state_q == S_REQ);
  assign exc_type_o     = exc_type_q;
  assign exc_pc_o       = exc_pc_q;
  assign busy_o         = (state_q != S_IDLE);
  assign status_valid_o = status_valid_q;
  assign status_type_o  = status_type_q;
  assign status_pc_o    = status_pc_q;
  assign overflow_o     = overflow_q;

`ifdef DIFT_TRAP_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
      // Counts every valid trap of this class outside BLANK, saturating.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_q[gi] <= '0;
        else if (clear_i)
          cnt_q[gi] <= '0;
        else if (trap_valid && (trap_type_i == 3'(gi)) &&
                 (state_q != S_BLANK) && (cnt_q[gi] != {CNT_W{1'b1}}))
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
  endgenerate

  // Counter read mux; unused selects read zero.
  always_comb begin
    cnt_data_o = '0;
    case (cnt_sel_i)
      3'd0:    cnt_data_o = cnt_q[0];
      3'd1:    cnt_data_o = cnt_q[1];
      3'd2:    cnt_data_o = cnt_q[2];
      3'd3:    cnt_data_o = cnt_q[3];
      3'd4:    cnt_data_o = cnt_q[4];
      default: cnt_data_o = '0;
    endcase
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel_i;
  assign cnt_data_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dift_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dift_trap_ctrl
// Purpose  : Self-checking bench for dift_trap_ctrl: directed vector table,
//            async reset and saturation sequences, then random traffic
//            against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dift_trap_ctrl;

`ifdef DIFT_TRAP_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_W = 4;
  localparam int PC_W  = 32;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            trap_i;
  logic [2:0]      trap_type_i;
  logic [PC_W-1:0] trap_pc_i;
  logic [4:0]      trap_mask_i;
  logic            exc_ack_i, flush_i, clear_i;
  logic            exc_req_o;
  logic [2:0]      exc_type_o;
  logic [PC_W-1:0] exc_pc_o;
  logic            busy_o, status_valid_o, overflow_o;
  logic [2:0]      status_type_o;
  logic [PC_W-1:0] status_pc_o;
  logic [2:0]      cnt_sel_i;
  logic [CNT_W-1:0] cnt_data_o;

  dift_trap_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .trap_i(trap_i), .trap_type_i(trap_type_i),
    .trap_pc_i(trap_pc_i), .trap_mask_i(trap_mask_i), .exc_ack_i(exc_ack_i),
    .flush_i(flush_i), .clear_i(clear_i), .exc_req_o(exc_req_o),
    .exc_type_o(exc_type_o), .exc_pc_o(exc_pc_o), .busy_o(busy_o),
    .status_valid_o(status_valid_o), .status_type_o(status_type_o),
    .status_pc_o(status_pc_o), .overflow_o(overflow_o),
    .cnt_sel_i(cnt_sel_i), .cnt_data_o(cnt_data_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending request / blanking window are tracked as plain flags.
  bit          m_pending, m_blank, m_sv, m_ov;
  logic [2:0]  m_etype, m_stype;
  logic [31:0] m_epc, m_spc;
  int          m_cnt [5];

  function automatic void model_reset();
    m_pending = 0; m_blank = 0; m_sv = 0; m_ov = 0;
    m_etype = 0; m_stype = 0; m_epc = 0; m_spc = 0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_clock();
    bit was_pending, was_blank, valid, raise;
    int t;
    t           = int'(trap_type_i);
    valid       = trap_i && (t <= 4);
    raise       = valid && trap_mask_i[t];
    was_pending = m_pending;
    was_blank   = m_blank;
    if (CNT_EN && valid && !was_blank && !clear_i && m_cnt[t] < CMAX)
      m_cnt[t] = m_cnt[t] + 1;
    if (was_blank) begin
      m_blank = 0;
    end else if (was_pending) begin
      if (raise && !clear_i) m_ov = 1;
      if (exc_ack_i) begin m_pending = 0; m_blank = 1; end
      else if (flush_i) m_pending = 0;
    end else if (raise) begin
      m_pending = 1;
      m_etype   = trap_type_i;
      m_epc     = trap_pc_i;
      if (!m_sv && !clear_i) begin
        m_sv = 1; m_stype = trap_type_i; m_spc = trap_pc_i;
      end
    end
    if (clear_i) begin
      m_sv = 0; m_stype = 0; m_spc = 0; m_ov = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end
  endfunction

  task automatic model_compare();
    int s;
    s = int'(cnt_sel_i);
    chk("req",   32'(exc_req_o), 32'(m_pending));
    chk("busy",  32'(busy_o), 32'(m_pending || m_blank));
    chk("etype", 32'(exc_type_o), 32'(m_etype));
    chk("epc",   exc_pc_o, m_epc);
    chk("sv",    32'(status_valid_o), 32'(m_sv));
    chk("stype", 32'(status_type_o), 32'(m_stype));
    chk("spc",   status_pc_o, m_spc);
    chk("ovf",   32'(overflow_o), 32'(m_ov));
    chk("cnt",   32'(cnt_data_o), (s <= 4) ? 32'(m_cnt[s]) : 32'd0);
  endtask

  task automatic idle_inputs();
    trap_i = 0; trap_type_i = 0; trap_pc_i = 0; trap_mask_i = 5'h1F;
    exc_ack_i = 0; flush_i = 0; clear_i = 0;
  endtask

  task automatic mstep();
    @(posedge clk);
    model_clock();
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic trap; logic [2:0] ty; logic [31:0] pc; logic [4:0] mask;
    logic ack; logic flush; logic clr; logic [2:0] sel;
    logic req; logic busy; logic [2:0] etype; logic [31:0] epc;
    logic sv; logic [2:0] stype; logic [31:0] spc; logic ov; logic [3:0] cnt;
  } vec_t;

  function automatic logic [3:0] cx(input int v);
    return CNT_EN ? 4'(v) : 4'd0;
  endfunction

  function automatic vec_t mk(
    input logic trap, input logic [2:0] ty, input logic [31:0] pc, input logic [4:0] mask,
    input logic ack, input logic flush, input logic clr, input logic [2:0] sel,
    input logic req, input logic busy, input logic [2:0] etype, input logic [31:0] epc,
    input logic sv, input logic [2:0] stype, input logic [31:0] spc, input logic ov,
    input int cnt);
    vec_t v;
    v.trap = trap; v.ty = ty; v.pc = pc; v.mask = mask; v.ack = ack; v.flush = flush;
    v.clr = clr; v.sel = sel; v.req = req; v.busy = busy; v.etype = etype; v.epc = epc;
    v.sv = sv; v.stype = stype; v.spc = spc; v.ov = ov; v.cnt = cx(cnt);
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    // trap ty pc mask ack fl clr sel | req busy ety epc sv sty spc ov cnt
    tbl[0]  = mk(1, 2, 32'h100, 5'h1F, 0, 0, 0, 2, 1, 1, 2, 32'h100, 1, 2, 32'h100, 0, 1);
    tbl[1]  = mk(0, 0, 32'h0,   5'h1F, 0, 0, 0, 2, 1, 1, 2, 32'h100, 1, 2, 32'h100, 0, 1);
    tbl[2]  = mk(0, 0, 32'h0,   5'h1F, 0, 0, 0, 2, 1, 1, 2, 32'h100, 1, 2, 32'h100, 0, 1);
    tbl[3]  = mk(0, 0, 32'h0,   5'h1F, 0, 0, 0, 2, 1, 1, 2, 32'h100, 1, 2, 32'h100, 0, 1);
    tbl[4]  = mk(0, 0, 32'h0,   5'h1F, 1, 0, 0, 4, 0, 1, 2, 32'h100, 1, 2, 32'h100, 0, 0);
    tbl[5]  = mk(1, 4, 32'h200, 5'h1F, 0, 0, 0, 4, 0, 0, 2, 32'h100, 1, 2, 32'h100, 0, 0);
    tbl[6]  = mk(0, 0, 32'h0,   5'h1F, 0, 0, 1, 2, 0, 0, 2, 32'h100, 0, 0, 32'h0,   0, 0);
    tbl[7]  = mk(1, 1, 32'h300, 5'h1D, 0, 0, 0, 1, 0, 0, 2, 32'h100, 0, 0, 32'h0,   0, 1);
    tbl[8]  = mk(1, 3, 32'h400, 5'h1F, 0, 0, 0, 3, 1, 1, 3, 32'h400, 1, 3, 32'h400, 0, 1);
    tbl[9]  = mk(0, 0, 32'h0,   5'h1F, 0, 1, 0, 3, 0, 0, 3, 32'h400, 1, 3, 32'h400, 0, 1);
    tbl[10] = mk(1, 0, 32'h500, 5'h1F, 0, 0, 0, 0, 1, 1, 0, 32'h500, 1, 3, 32'h400, 0, 1);
    tbl[11] = mk(1, 4, 32'h600, 5'h1F, 0, 0, 0, 4, 1, 1, 0, 32'h500, 1, 3, 32'h400, 1, 1);
    tbl[12] = mk(0, 0, 32'h0,   5'h1F, 1, 1, 0, 4, 0, 1, 0, 32'h500, 1, 3, 32'h400, 1, 1);
    tbl[13] = mk(0, 0, 32'h0,   5'h1F, 0, 0, 0, 4, 0, 0, 0, 32'h500, 1, 3, 32'h400, 1, 1);
    tbl[14] = mk(1, 2, 32'h700, 5'h1F, 0, 0, 1, 2, 1, 1, 2, 32'h700, 0, 0, 32'h0,   0, 0);
    tbl[15] = mk(0, 0, 32'h0,   5'h1F, 1, 0, 0, 2, 0, 1, 2, 32'h700, 0, 0, 32'h0,   0, 0);
    tbl[16] = mk(0, 0, 32'h0,   5'h1F, 0, 0, 0, 7, 0, 0, 2, 32'h700, 0, 0, 32'h0,   0, 0);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0;
    idle_inputs();
    cnt_sel_i = 0;
    #1;
    chk("rst_req",  32'(exc_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_sv",   32'(status_valid_o), 0);
    chk("rst_ovf",  32'(overflow_o), 0);
    chk("rst_epc",  exc_pc_o, 0);
    chk("rst_cnt",  32'(cnt_data_o), 0);
    do_reset();

    // Directed table
    for (int i = 0; i < 17; i++) begin
      trap_i = tbl[i].trap; trap_type_i = tbl[i].ty; trap_pc_i = tbl[i].pc;
      trap_mask_i = tbl[i].mask; exc_ack_i = tbl[i].ack; flush_i = tbl[i].flush;
      clear_i = tbl[i].clr; cnt_sel_i = tbl[i].sel;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),   32'(exc_req_o), 32'(tbl[i].req));
      chk($sformatf("v%0d_busy", i),  32'(busy_o), 32'(tbl[i].busy));
      chk($sformatf("v%0d_etype", i), 32'(exc_type_o), 32'(tbl[i].etype));
      chk($sformatf("v%0d_epc", i),   exc_pc_o, tbl[i].epc);
      chk($sformatf("v%0d_sv", i),    32'(status_valid_o), 32'(tbl[i].sv));
      chk($sformatf("v%0d_stype", i), 32'(status_type_o), 32'(tbl[i].stype));
      chk($sformatf("v%0d_spc", i),   status_pc_o, tbl[i].spc);
      chk($sformatf("v%0d_ovf", i),   32'(overflow_o), 32'(tbl[i].ov));
      chk($sformatf("v%0d_cnt", i),   32'(cnt_data_o), 32'(tbl[i].cnt));
    end

    // Async reset while requesting: request drops without a clock edge
    do_reset();
    trap_i = 1; trap_type_i = 3'd3; trap_pc_i = 32'h800; cnt_sel_i = 3'd3;
    mstep();
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    chk("arst_req",  32'(exc_req_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_sv",   32'(status_valid_o), 0);
    chk("arst_cnt",  32'(cnt_data_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (3) mstep();

    // Saturation: 20 accepted EXEC traps, each acked
    cnt_sel_i = 3'd0;
    for (int i = 0; i < 20; i++) begin
      trap_i = 1; trap_type_i = 3'd0; trap_pc_i = 32'h1000 + 32'(i * 4);
      mstep();
      idle_inputs(); exc_ack_i = 1;
      mstep();
      idle_inputs();
      mstep();
    end
    chk("sat_cnt0", 32'(cnt_data_o), CNT_EN ? 32'd15 : 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trap_i      = ($urandom_range(0, 99) < 50);
      trap_type_i = 3'($urandom_range(0, 7));
      trap_pc_i   = $urandom & 32'hFFFF_FFFC;
      trap_mask_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
      exc_ack_i   = ($urandom_range(0, 99) < 30);
      flush_i     = ($urandom_range(0, 99) < 15);
      clear_i     = ($urandom_range(0, 99) < 3);
      cnt_sel_i   = 3'($urandom_range(0, 7));
      mstep();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
